// File: rtl/spi_flash_burst_reader_if.sv
// Bus bundle for spi_flash_burst_reader: control, byte stream and SPI flash pins.
// Stream handshake: a byte moves on every clk edge where data_valid and data_ready are both high;
// data_valid never drops and data never changes while a byte is waiting to be taken.
interface spi_flash_burst_reader_if #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [7:0]        data;
    logic              data_valid;
    logic              data_ready;
    logic              spi_sck;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;

    modport slave (
        input  start, addr, len, data_ready, spi_miso,
        output busy, done, data, data_valid, spi_sck, spi_cs_n, spi_mosi
    );

    modport master (
        output start, addr, len, data_ready, spi_miso,
        input  busy, done, data, data_valid, spi_sck, spi_cs_n, spi_mosi
    );
endinterface

// File: rtl/spi_flash_burst_reader.sv
// Fast Read (CMD) burst reader: streams len bytes from SPI flash over valid/ready, pausing SCK on backpressure.
// Optional abort input is built when SPI_FLASH_ABORT_EN is defined.
module spi_flash_burst_reader #(
    parameter int         ADDR_W       = 24,
    parameter int         LEN_W        = 8,
    parameter int         CLK_DIV      = 2,
    parameter int         DUMMY_CYCLES = 8,
    parameter int         CS_HIGH      = 4,
    parameter logic [7:0] CMD          = 8'h0B
) (
    input  logic                     clk,
    input  logic                     rstn,
`ifdef SPI_FLASH_ABORT_EN
    input  logic                     abort,
`endif
    spi_flash_burst_reader_if.slave  bus,
    output logic [2:0]               dbg_state
);

    localparam int TX_W  = 8 + ADDR_W;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CSH_W = (CS_HIGH > 1) ? $clog2(CS_HIGH) : 1;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DUMMY  = 3'd3,
        ST_DATA   = 3'd4,
        ST_STALL  = 3'd5,
        ST_FINISH = 3'd6
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [CSH_W-1:0]  cs_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [TX_W-1:0]   tx_sr;
    logic [7:0]        rx_sr;
    logic [2:0]        rx_bits;
    logic [LEN_W-1:0]  remaining;
    logic [7:0]        data_q;
    logic [7:0]        pend_byte;
    logic              pend;
    logic              data_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              sck_q;
    logic              cs_n_q;
    logic              mosi_q;

    logic              active;
    logic              tick;
    logic              sck_rise;
    logic              sck_fall;
    logic              can_load;
    logic              pend_load;
    logic [7:0]        rx_byte;
    logic              abort_hit;

    assign active    = state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
    assign tick      = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign sck_rise  = tick && !sck_q;
    assign sck_fall  = tick && sck_q;
    assign can_load  = !data_valid_q || bus.data_ready;
    assign pend_load = pend && can_load;
    assign rx_byte   = {rx_sr[6:0], bus.spi_miso};

`ifdef SPI_FLASH_ABORT_EN
    assign abort_hit = abort && (state != ST_IDLE) && (state != ST_FINISH);
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            cs_cnt       <= '0;
            bit_cnt      <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            rx_bits      <= '0;
            remaining    <= '0;
            data_q       <= '0;
            pend_byte    <= '0;
            pend         <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sck_q        <= 1'b0;
            cs_n_q       <= 1'b1;
            mosi_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Output slot: a parked byte moves in as soon as the slot frees up, in any state.
            if (pend_load) begin
                data_q       <= pend_byte;
                data_valid_q <= 1'b1;
                pend         <= 1'b0;
            end else if (data_valid_q && bus.data_ready) begin
                data_valid_q <= 1'b0;
            end

            if (active) begin
                if (tick) begin
                    div_cnt <= '0;
                    sck_q   <= ~sck_q;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            if (abort_hit) begin
                // The byte in data survives; partial and parked bytes are dropped.
                state   <= ST_FINISH;
                sck_q   <= 1'b0;
                cs_n_q  <= 1'b1;
                mosi_q  <= 1'b0;
                div_cnt <= '0;
                cs_cnt  <= '0;
                pend    <= 1'b0;
                rx_bits <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            if (bus.len != '0) begin
                                tx_sr     <= {CMD, bus.addr};
                                remaining <= bus.len;
                                mosi_q    <= CMD[7];
                                cs_n_q    <= 1'b0;
                                busy_q    <= 1'b1;
                                bit_cnt   <= '0;
                                rx_bits   <= '0;
                                div_cnt   <= '0;
                                sck_q     <= 1'b0;
                                state     <= ST_CMD;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end

                    ST_CMD: begin
                        if (sck_fall) begin
                            mosi_q <= tx_sr[TX_W-2];
                            tx_sr  <= {tx_sr[TX_W-2:0], 1'b1};
                            if (bit_cnt == CNT_W'(7)) begin
                                bit_cnt <= '0;
                                state   <= ST_ADDR;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ST_ADDR: begin
                        // tx_sr back-fills with ones so mosi idles high through dummy and data.
                        if (sck_fall) begin
                            mosi_q <= tx_sr[TX_W-2];
                            tx_sr  <= {tx_sr[TX_W-2:0], 1'b1};
                            if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                                bit_cnt <= '0;
                                state   <= (DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ST_DUMMY: begin
                        if (sck_fall) begin
                            if (bit_cnt == CNT_W'(DUMMY_CYCLES - 1)) begin
                                bit_cnt <= '0;
                                state   <= ST_DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ST_DATA: begin
                        if (sck_rise) begin
                            rx_sr   <= rx_byte;
                            rx_bits <= rx_bits + 1'b1;
                            if (rx_bits == 3'd7) begin
                                remaining <= remaining - 1'b1;
                                if (can_load) begin
                                    data_q       <= rx_byte;
                                    data_valid_q <= 1'b1;
                                end else begin
                                    pend      <= 1'b1;
                                    pend_byte <= rx_byte;
                                end
                            end
                        end else if (sck_fall) begin
                            // Stall only with SCK back low, so the flash sees a clean pause.
                            if (pend && !can_load) begin
                                state <= ST_STALL;
                            end else if (remaining == '0) begin
                                state  <= ST_FINISH;
                                cs_n_q <= 1'b1;
                                mosi_q <= 1'b0;
                                cs_cnt <= '0;
                            end
                        end
                    end

                    ST_STALL: begin
                        if (pend_load) begin
                            if (remaining == '0) begin
                                state  <= ST_FINISH;
                                cs_n_q <= 1'b1;
                                mosi_q <= 1'b0;
                                cs_cnt <= '0;
                            end else begin
                                state <= ST_DATA;
                            end
                        end
                    end

                    ST_FINISH: begin
                        if (cs_cnt == CSH_W'(CS_HIGH - 1)) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            cs_cnt <= cs_cnt + 1'b1;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.data       = data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.spi_sck    = sck_q;
    assign bus.spi_cs_n   = cs_n_q;
    assign bus.spi_mosi   = mosi_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_spi_flash_burst_reader.sv
// Directed bench for spi_flash_burst_reader with a mode-0 flash model and a byte scoreboard.
// Define SPI_FLASH_ABORT_EN to also exercise the abort input.
module tb_spi_flash_burst_reader;

    logic       clk;
    logic       rstn;
    logic       abort;
    logic [2:0] dbg_state;

    spi_flash_burst_reader_if #(.ADDR_W(24), .LEN_W(8)) bus ();

    spi_flash_burst_reader dut (
        .clk       (clk),
        .rstn      (rstn),
`ifdef SPI_FLASH_ABORT_EN
        .abort     (abort),
`endif
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  exp_q[$];
    int          done_cnt;
    int          rx_cnt;
    int          sck_rises;
    int          rise_n;
    logic [31:0] mosi_cap;
    logic        cs_low_seen;
    logic        busy_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a, input int idx);
        logic [7:0] tbl [8];
        tbl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        if (a == 24'h400000 && idx >= 0 && idx < 8) return tbl[idx];
        return 8'hEE;
    endfunction

    // flash model: captures cmd+addr on rises, drives miso on falls after 8 dummy clocks
    int         fb_bit;
    logic [7:0] fb;
    always @(posedge bus.spi_sck or negedge bus.spi_sck or posedge bus.spi_cs_n or negedge bus.spi_cs_n) begin
        if (bus.spi_cs_n) begin
            rise_n = 0;
        end else if (bus.spi_sck) begin
            if (rise_n < 32) mosi_cap = {mosi_cap[30:0], bus.spi_mosi};
            rise_n++;
            sck_rises++;
        end else if (rise_n >= 40) begin
            fb_bit       = rise_n - 40;
            fb           = flash_byte(mosi_cap[23:0], fb_bit / 8);
            bus.spi_miso = fb[7 - (fb_bit % 8)];
        end
    end

    // scoreboard / monitor
    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (!bus.spi_cs_n) cs_low_seen = 1'b1;
        if (bus.busy) busy_seen = 1'b1;
        if (bus.data_valid && bus.data_ready) begin
            check("byte_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("byte_value", bus.data, exp_q.pop_front());
            rx_cnt++;
        end
    end

    task automatic clear_counts();
        done_cnt    = 0;
        rx_cnt      = 0;
        sck_rises   = 0;
        mosi_cap    = '0;
        cs_low_seen = 1'b0;
        busy_seen   = 1'b0;
    endtask

    task automatic push4();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
    endtask

    task automatic start_burst(input logic [23:0] a, input logic [7:0] l);
        bus.addr  = a;
        bus.len   = l;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        int base;
        n    = 0;
        base = done_cnt;
        while (done_cnt == base && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_done_timeout"}, n < 3000, 1);
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 1;
        while (!bus.data_valid && cyc < 1000) begin
            tick();
            cyc++;
        end
        check({tag, "_valid_timeout"}, cyc < 1000, 1);
    endtask

    int cyc;
    int sck_hi;
    int cs_hi;

    initial begin
        bus.start      = 1'b0;
        bus.addr       = '0;
        bus.len        = '0;
        bus.data_ready = 1'b1;
        bus.spi_miso   = 1'b0;
        abort          = 1'b0;
        rise_n         = 0;
        clear_counts();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (3) tick();

        // reset values
        check("rst_cs_n", bus.spi_cs_n, 1);
        check("rst_sck", bus.spi_sck, 0);
        check("rst_mosi", bus.spi_mosi, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_valid", bus.data_valid, 0);
        check("rst_data", bus.data, 0);
        check("rst_state", dbg_state, 0);
        rstn = 1'b1;
        repeat (2) tick();

        // basic burst, 4 bytes, consumer always ready
        clear_counts();
        push4();
        start_burst(24'h400000, 8'd4);
        check("t1_busy", bus.busy, 1);
        check("t1_cs_n", bus.spi_cs_n, 0);
        check("t1_mosi_bit0", bus.spi_mosi, 0);
        wait_valid("t1", cyc);
        check("t1_latency", (cyc >= 189 && cyc <= 193), 1);
        wait_done("t1");
        repeat (5) tick();
        check("t1_done_cnt", done_cnt, 1);
        check("t1_mosi_cmd_addr", mosi_cap, 32'h0B400000);
        check("t1_sck_cycles", sck_rises, 72);
        check("t1_rx_cnt", rx_cnt, 4);
        check("t1_exp_empty", exp_q.size(), 0);
        check("t1_busy_after", bus.busy, 0);

        // backpressure after the first byte
        clear_counts();
        push4();
        start_burst(24'h400000, 8'd4);
        wait_valid("t2", cyc);
        tick();
        bus.data_ready = 1'b0;
        sck_hi = 0;
        cs_hi  = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i >= 80) begin
                if (bus.spi_sck) sck_hi++;
                if (bus.spi_cs_n) cs_hi++;
            end
        end
        check("t2_sck_frozen", sck_hi, 0);
        check("t2_cs_held", cs_hi, 0);
        check("t2_state_stall", dbg_state, 5);
        check("t2_rx_during_stall", rx_cnt, 1);
        bus.data_ready = 1'b1;
        wait_done("t2");
        repeat (5) tick();
        check("t2_rx_cnt", rx_cnt, 4);
        check("t2_exp_empty", exp_q.size(), 0);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_sck_cycles", sck_rises, 72);

        // zero-length request
        clear_counts();
        start_burst(24'h400000, 8'd0);
        check("t3_done_now", bus.done, 1);
        check("t3_busy_now", bus.busy, 0);
        tick();
        check("t3_done_gone", bus.done, 0);
        repeat (10) tick();
        check("t3_cs_never_low", cs_low_seen, 0);
        check("t3_busy_never", busy_seen, 0);
        check("t3_done_cnt", done_cnt, 1);

        // start while busy is ignored
        clear_counts();
        push4();
        start_burst(24'h400000, 8'd4);
        repeat (50) tick();
        start_burst(24'h000000, 8'd5);
        wait_done("t4");
        repeat (200) tick();
        check("t4_done_cnt", done_cnt, 1);
        check("t4_rx_cnt", rx_cnt, 4);
        check("t4_exp_empty", exp_q.size(), 0);
        check("t4_mosi_cmd_addr", mosi_cap, 32'h0B400000);
        check("t4_no_second_txn", sck_rises, 72);
        check("t4_state_idle", dbg_state, 0);

        // asynchronous reset mid-ADDR, then a clean transaction
        clear_counts();
        push4();
        start_burst(24'h400000, 8'd4);
        repeat (60) tick();
        check("t5_in_addr", dbg_state, 2);
        #2 rstn = 1'b0;
        #1;
        check("t5_rst_cs_n", bus.spi_cs_n, 1);
        check("t5_rst_sck", bus.spi_sck, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_valid", bus.data_valid, 0);
        check("t5_rst_state", dbg_state, 0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        check("t5_no_done_on_reset", done_cnt, 0);
        exp_q.delete();
        clear_counts();
        push4();
        start_burst(24'h400000, 8'd4);
        wait_done("t5");
        repeat (5) tick();
        check("t5_rx_cnt", rx_cnt, 4);
        check("t5_exp_empty", exp_q.size(), 0);
        check("t5_done_cnt", done_cnt, 1);
        check("t5_mosi_cmd_addr", mosi_cap, 32'h0B400000);

`ifdef SPI_FLASH_ABORT_EN
        // abort after the second of eight bytes
        clear_counts();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        start_burst(24'h400000, 8'd8);
        cyc = 0;
        while (rx_cnt < 2 && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("t6_two_bytes_timeout", cyc < 1000, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_cs_n_high", bus.spi_cs_n, 1);
        check("t6_sck_low", bus.spi_sck, 0);
        wait_done("t6");
        repeat (50) tick();
        check("t6_rx_cnt", rx_cnt, 2);
        check("t6_exp_empty", exp_q.size(), 0);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_busy", bus.busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
